led_seq_decoder: RTL and testbench

LED_SEQ_DECODER -- requirements
Module: led_seq_decoder

---
 rtl/led_seq_decoder_if.sv | 23 ++
 rtl/led_seq_decoder.sv | 161 ++++++++++++++++
 tb/tb_led_seq_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_seq_decoder_if.sv
// Sample/status bundle between an LED sequence source and its decoder.
interface led_seq_decoder_if #(
  parameter int ERR_W = 8
);
  logic [7:0]       led;
  logic             vld;
  logic [1:0]       mode;
  logic [2:0]       step;
  logic             lock;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output led, vld,
    input  mode, step, lock, err, wrap, err_cnt
  );

  modport slave (
    input  led, vld,
    output mode, step, lock, err, wrap, err_cnt
  );
endinterface

// File: rtl/led_seq_decoder.sv
// Tracks an 8-LED shift/fill sequence, reporting phase,
// lock, wrap and saturating error statistics.
module led_seq_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             ck,
  input  logic             rs,
  led_seq_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    ZERO  = 2'b01,
    SHIFT = 2'b10,
    FILL  = 2'b11
  } mode_e;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] CNT_ONE =
    {{(ERR_W-1){1'b0}}, 1'b1};

  mode_e            state;
  mode_e            state_n;
  logic [7:0]       last;
  logic [7:0]       last_n;
  logic [3:0]       good;
  logic [3:0]       good_n;
  logic [3:0]       good_inc;
  logic [2:0]       step_q;
  logic [2:0]       step_n;
  logic             lock_q;
  logic             lock_n;
  logic             err_q;
  logic             err_n;
  logic             wrap_q;
  logic             wrap_n;
  logic [ERR_W-1:0] cnt_q;
  logic [ERR_W-1:0] cnt_n;

  logic             zero;
  logic             legal;
  logic             wrap_hit;
  logic [7:0]       shift_nxt;
  logic [7:0]       fill_nxt;

  function automatic logic [2:0] msb_idx(
    input logic [7:0] p
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign zero      = (bus.led == 8'h00);
  assign shift_nxt = {last[0], last[7:1]};
  assign fill_nxt  = (last == 8'hFF) ? 8'h01
                                     : {last[6:0], 1'b1};
  assign good_inc  = (good == 4'hF) ? good
                                    : good + 4'd1;

  // state register
  always_ff @(posedge ck) begin
    if (rs) state <= HUNT;
    else    state <= state_n;
  end

  // next-state logic; 01 means FILL entry only from ZERO
  always_comb begin
    legal    = 1'b0;
    wrap_hit = 1'b0;
    state_n  = state;
    unique case (state)
      HUNT:  legal = 1'b0;
      ZERO:  legal = (bus.led == 8'h80) ||
                     (bus.led == 8'h01);
      SHIFT: begin
        legal    = (bus.led == shift_nxt);
        wrap_hit = (last == 8'h01);
      end
      FILL: begin
        legal    = (bus.led == fill_nxt);
        wrap_hit = (last == 8'hFF);
      end
    endcase
    if (bus.vld) begin
      if (zero) begin
        state_n = ZERO;
      end else if (state != HUNT) begin
        if (!legal)
          state_n = HUNT;
        else if (state == ZERO)
          state_n = bus.led[7] ? SHIFT : FILL;
      end
    end
  end

  // output/datapath next values
  always_comb begin
    last_n = last;
    good_n = good;
    step_n = step_q;
    lock_n = lock_q;
    err_n  = 1'b0;
    wrap_n = 1'b0;
    cnt_n  = cnt_q;
    if (bus.vld) begin
      if (zero) begin
        last_n = 8'h00;
        good_n = 4'd1;
        step_n = 3'd0;
      end else if (state != HUNT) begin
        if (legal) begin
          last_n = bus.led;
          good_n = good_inc;
          step_n = msb_idx(bus.led);
          wrap_n = wrap_hit;
          lock_n = lock_q | (good_inc >= LOCK_TH);
        end else begin
          err_n  = 1'b1;
          last_n = 8'h00;
          good_n = 4'd0;
          step_n = 3'd0;
          lock_n = 1'b0;
          if (cnt_q != '1) cnt_n = cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rs) begin
      last   <= 8'h00;
      good   <= 4'd0;
      step_q <= 3'd0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      last   <= last_n;
      good   <= good_n;
      step_q <= step_n;
      lock_q <= lock_n;
      err_q  <= err_n;
      wrap_q <= wrap_n;
      cnt_q  <= cnt_n;
    end
  end

  assign bus.mode    = state;
  assign bus.step    = step_q;
  assign bus.lock    = lock_q;
  assign bus.err     = err_q;
  assign bus.wrap    = wrap_q;
  assign bus.err_cnt = cnt_q;

endmodule

// File: tb/tb_led_seq_decoder.sv
// Directed bench for led_seq_decoder with a sequence-table
// reference model checked every cycle.
module tb_led_seq_decoder;

  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic ck = 1'b0;
  logic rs = 1'b1;

  led_seq_decoder_if #(.ERR_W(ERR_W)) bus();

  led_seq_decoder #(
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .ck (ck),
    .rs (rs),
    .bus(bus)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // legal non-zero patterns, in order, for each sequence
  logic [7:0] sh_tab [8] = '{8'h80, 8'h40, 8'h20, 8'h10,
                             8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] fl_tab [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                             8'h1F, 8'h3F, 8'h7F, 8'hFF};

  // model: 0 hunt, 1 zero, 2 shift, 3 fill
  int m_mode, m_idx, m_good, m_step, m_cnt;
  bit m_lock, m_err, m_wrap;

  task automatic m_bad();
    m_err  = 1;
    m_mode = 0;
    m_lock = 0;
    m_good = 0;
    m_idx  = 0;
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic m_good_hit(int mode, int idx);
    m_wrap = (m_mode == mode) && (idx == 0);
    m_mode = mode;
    m_idx  = idx;
    if (m_good < 15) m_good++;
  endtask

  task automatic model_edge(bit r, bit v, logic [7:0] l);
    int nx;
    m_err  = 0;
    m_wrap = 0;
    if (r) begin
      m_mode = 0; m_idx = 0; m_good = 0;
      m_lock = 0; m_cnt = 0;
    end else if (v) begin
      nx = (m_idx + 1) % 8;
      if (l == 8'h00) begin
        m_mode = 1;
        m_good = 1;
      end else if (m_mode == 1) begin
        if (l == sh_tab[0])      m_good_hit(2, 0);
        else if (l == fl_tab[0]) m_good_hit(3, 0);
        else                     m_bad();
      end else if (m_mode == 2) begin
        if (l == sh_tab[nx]) m_good_hit(2, nx);
        else                 m_bad();
      end else if (m_mode == 3) begin
        if (l == fl_tab[nx]) m_good_hit(3, nx);
        else                 m_bad();
      end
      if (m_good >= LOCK_CNT) m_lock = 1;
    end
    m_step = (m_mode == 2) ? 7 - m_idx :
             (m_mode == 3) ? m_idx : 0;
  endtask

  always @(posedge ck) model_edge(rs, bus.vld, bus.led);

  always @(negedge ck) begin
    if (armed) begin
      checks++;
      if (bus.mode !== 2'(m_mode) ||
          bus.step !== 3'(m_step) ||
          bus.lock !== m_lock ||
          bus.err  !== m_err  ||
          bus.wrap !== m_wrap ||
          bus.err_cnt !== ERR_W'(m_cnt)) begin
        errors++;
        $display("FAIL model t=%0t got m%0d s%0d l%0b e%0b w%0b c%0d req m%0d s%0d l%0b e%0b w%0b c%0d",
                 $time, bus.mode, bus.step, bus.lock, bus.err,
                 bus.wrap, bus.err_cnt, m_mode, m_step, m_lock,
                 m_err, m_wrap, m_cnt);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(bit r, bit v, logic [7:0] l);
    rs      = r;
    bus.vld = v;
    bus.led = l;
    @(negedge ck);
  endtask

  task automatic smp(logic [7:0] l);
    cyc(0, 1, l);
  endtask

  task automatic rst();
    cyc(1, 0, 8'h00);
  endtask

  logic [7:0] sh_seq [10] = '{8'h00, 8'h80, 8'h40, 8'h20,
                              8'h10, 8'h08, 8'h04, 8'h02,
                              8'h01, 8'h80};
  logic [7:0] fl_seq [10] = '{8'h00, 8'h01, 8'h03, 8'h07,
                              8'h0F, 8'h1F, 8'h3F, 8'h7F,
                              8'hFF, 8'h01};

  initial begin
    bus.vld = 1'b0;
    bus.led = 8'h00;
    @(negedge ck);
    rst();
    armed = 1;
    rst();
    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_lock", 32'(bus.lock), 0);
    chk("rst_cnt", 32'(bus.err_cnt), 0);

    // shift sequence with wrap
    for (int i = 0; i < 10; i++) begin
      smp(sh_seq[i]);
      if (i == 2) chk("sh_nolock40", 32'(bus.lock), 0);
      if (i == 3) chk("sh_lock20", 32'(bus.lock), 1);
      if (i == 4) chk("sh_step10", 32'(bus.step), 4);
      if (i == 8) chk("sh_nowrap01", 32'(bus.wrap), 0);
    end
    chk("sh_wrap", 32'(bus.wrap), 1);
    chk("sh_step", 32'(bus.step), 7);
    chk("sh_mode", 32'(bus.mode), 2);
    smp(8'h40);
    chk("sh_wrap_pulse", 32'(bus.wrap), 0);

    // fill sequence with wrap
    rst();
    for (int i = 0; i < 10; i++) begin
      smp(fl_seq[i]);
      if (i == 2) chk("fl_nolock03", 32'(bus.lock), 0);
      if (i == 3) chk("fl_lock07", 32'(bus.lock), 1);
      if (i == 8) chk("fl_stepff", 32'(bus.step), 7);
    end
    chk("fl_wrap", 32'(bus.wrap), 1);
    chk("fl_step", 32'(bus.step), 0);
    chk("fl_mode", 32'(bus.mode), 3);

    // illegal sample in shift
    rst();
    smp(8'h00); smp(8'h80); smp(8'h40); smp(8'h20);
    smp(8'h08);
    chk("er_err", 32'(bus.err), 1);
    chk("er_cnt", 32'(bus.err_cnt), 1);
    chk("er_mode", 32'(bus.mode), 0);
    chk("er_lock", 32'(bus.lock), 0);
    smp(8'h55);
    chk("hunt_noerr", 32'(bus.err), 0);
    chk("hunt_cnt", 32'(bus.err_cnt), 1);
    smp(8'h00);
    chk("er_zero", 32'(bus.mode), 1);
    smp(8'h01);
    chk("er_fill", 32'(bus.mode), 3);
    chk("er_none", 32'(bus.err), 0);

    // locked shift, back through zero into fill
    rst();
    smp(8'h00); smp(8'h80); smp(8'h40); smp(8'h20);
    smp(8'h10);
    smp(8'h00);
    chk("mc_zero", 32'(bus.mode), 1);
    chk("mc_lock0", 32'(bus.lock), 1);
    smp(8'h01); smp(8'h03);
    chk("mc_fill", 32'(bus.mode), 3);
    chk("mc_lock1", 32'(bus.lock), 1);
    chk("mc_err", 32'(bus.err), 0);

    // vld gaps then a repeated pattern
    rst();
    smp(8'h00); smp(8'h80);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h40);
    chk("gap_mode", 32'(bus.mode), 2);
    chk("gap_step", 32'(bus.step), 7);
    smp(8'h80);
    chk("rep_err", 32'(bus.err), 1);
    chk("rep_cnt", 32'(bus.err_cnt), 1);

    // reset mid-sequence with an illegal sample present
    rst();
    smp(8'h00); smp(8'h80); smp(8'h40);
    cyc(1, 1, 8'h33);
    chk("mid_err", 32'(bus.err), 0);
    chk("mid_mode", 32'(bus.mode), 0);

    // counter saturation, then reset beats vld
    for (int i = 0; i < 300; i++) begin
      smp(8'h00); smp(8'h55);
    end
    chk("sat_cnt", 32'(bus.err_cnt), CNT_MAX);
    chk("sat_err", 32'(bus.err), 1);
    cyc(1, 1, 8'h00);
    chk("rv_cnt", 32'(bus.err_cnt), 0);
    chk("rv_mode", 32'(bus.mode), 0);
    chk("rv_err", 32'(bus.err), 0);
    cyc(0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
